// File: rtl/wb_writer.sv
// Writeback merge of ALU and load results onto the register file write port.
// Optional busy scoreboard is enabled with `define WB_SCOREBOARD_EN.
module wb_writer #(
    parameter int LD_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid_pi,
    input  logic [4:0]  alu_rd_pi,
    input  logic [31:0] alu_data_pi,
    input  logic        ld_valid_pi,
    output logic        ld_ready_po,
    input  logic [4:0]  ld_rd_pi,
    input  logic [31:0] ld_data_pi,
    input  logic        iss_valid_pi,
    input  logic [4:0]  iss_rd_pi,
    output logic        alu_stall_po,
    output logic        we_po,
    output logic [4:0]  destReg_po,
    output logic [31:0] writeData_po,
    output logic [31:0] busy_po
);
    localparam int AW = $clog2(LD_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(LD_FIFO_DEPTH);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [4:0]  fifo_rd   [LD_FIFO_DEPTH];
    logic [31:0] fifo_data [LD_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [7:0]  starve, starve_nxt;
    logic        stall_nxt;
    logic        push, pop, fifo_empty;
    logic        sel_any, wr_en;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    assign ld_ready_po = !reset && (count < DEPTH);
    assign fifo_empty  = (count == '0);
    assign push        = ld_valid_pi && ld_ready_po;
    assign pop         = !alu_valid_pi && !fifo_empty;

    always_comb begin
        sel_any  = alu_valid_pi || pop;
        sel_rd   = alu_valid_pi ? alu_rd_pi : fifo_rd[rd_ptr];
        sel_data = alu_valid_pi ? alu_data_pi : fifo_data[rd_ptr];
        wr_en    = sel_any && (sel_rd != 5'd0);
    end

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Counter saturates if upstream ignores the stall request.
    always_comb begin
        starve_nxt = starve;
        if (fifo_empty || pop)
            starve_nxt = 8'd0;
        else if (alu_valid_pi)
            starve_nxt = (starve >= LIMIT) ? LIMIT : starve + 8'd1;
        stall_nxt = alu_stall_po;
        if (pop)
            stall_nxt = 1'b0;
        else if (starve_nxt == LIMIT)
            stall_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= ld_rd_pi;
            fifo_data[wr_ptr] <= ld_data_pi;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            starve       <= 8'd0;
            alu_stall_po <= 1'b0;
            we_po        <= 1'b0;
            destReg_po   <= 5'd0;
            writeData_po <= 32'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count        <= count_nxt;
            starve       <= starve_nxt;
            alu_stall_po <= stall_nxt;
            we_po        <= wr_en;
            if (wr_en) begin
                destReg_po   <= sel_rd;
                writeData_po <= sel_data;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy, busy_nxt;

    // Set is applied after clear so a same-cycle reissue stays busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_en)
            busy_nxt[sel_rd] = 1'b0;
        if (iss_valid_pi && (iss_rd_pi != 5'd0))
            busy_nxt[iss_rd_pi] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            busy <= 32'd0;
        else
            busy <= busy_nxt;
    end

    assign busy_po = busy;
`else
    logic unused_iss;
    assign unused_iss = ^{iss_valid_pi, iss_rd_pi};
    assign busy_po    = 32'd0;
`endif

endmodule

// File: doc/wb_writer.md
# wb_writer

Writeback unit for the RV32I core that drives the register file write port. It merges results from the single-cycle ALU pipe and from the variable-latency load unit. ALU results have priority, and loads are buffered in a small FIFO with an anti-starvation stall. An optional scoreboard tracks destination registers with writes still outstanding, for hazard detection at issue.

## Interface
- LD_FIFO_DEPTH, 2: load result FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 8: consecutive cycles a valid FIFO head may be blocked by ALU writes before a stall is requested; range 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high; clock clk.
- alu_valid_pi  in  1  ALU result valid this cycle; no backpressure.
- alu_rd_pi  in  5  ALU destination register.
- alu_data_pi  in  32  ALU result.
- ld_valid_pi  in  1  load result offered.
- ld_ready_po  out  1  load result accepted when ld_valid_pi && ld_ready_po.
- ld_rd_pi  in  5  load destination register.
- ld_data_pi  in  32  load data, already extended.
- iss_valid_pi  in  1  an instruction writing iss_rd_pi issues this cycle.
- iss_rd_pi  in  5  issuing destination register.
- alu_stall_po  out  1  request that upstream hold alu_valid_pi low.
- we_po  out  1  register file write enable.
- destReg_po  out  5  register file write address.
- writeData_po  out  32  register file write data.
- busy_po  out  32  bit i set means a write to xi is outstanding.

## Operation
- Output register. Each cycle, the block selects one source and loads we_po, destReg_po and writeData_po on the next edge.
  - Priority: ALU input first, then the FIFO head.
  - With no source, we_po=0; destReg_po and writeData_po hold their last value.
- x0 handling. A selected entry with rd=0 is consumed (popped, or the ALU input taken), but we_po stays 0.
- Load FIFO.
  - An accepted load is pushed at the edge.
  - ld_ready_po = !reset && (count < LD_FIFO_DEPTH), using the registered count.
  - Push and pop in the same cycle is allowed when not full; count is unchanged.
  - Push when full cannot occur, because ready is low.
  - Pointers wrap modulo LD_FIFO_DEPTH.
- Starvation counter (8-bit).
  - Increments each cycle the FIFO is non-empty and alu_valid_pi takes the slot.
  - Clears on a pop, or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, alu_stall_po is registered high.
  - alu_stall_po clears on the edge after the next pop.
- ALU valid during stall. Upstream must not assert alu_valid_pi while alu_stall_po=1. If it does, the ALU still wins and the counter saturates at STARVE_LIMIT.
- Scoreboard (WB_SCOREBOARD_EN).
  - iss_valid_pi with rd≠0 sets busy[rd] at the edge.
  - busy[rd] clears on the edge that registers we_po=1 for rd.
  - If set and clear hit the same rd in the same cycle, set wins.
  - busy[0] is always 0.

## Timing
- Reset values:
  - we_po=0, destReg_po=0, writeData_po=0.
  - alu_stall_po=0, busy_po=0.
  - FIFO empty, counter=0.
  - ld_ready_po=0 while reset is high.
- Reset mid-operation discards all FIFO contents and outstanding busy bits.
- ALU latency: alu_valid_pi at cycle N gives we_po at N+1.
- Load latency: accepted at N, write at N+2 at the earliest (pop at N+1). Each consecutive ALU cycle adds one cycle of delay.
- With the FIFO full and no ALU traffic, the block sustains one load write per cycle and ld_ready_po recovers the cycle after a pop.
- The register file sees at most one write per cycle. Same-cycle read bypass is handled by the register file.

## Configuration
- WB_SCOREBOARD_EN defined: the busy bitmap is implemented as described above.
- WB_SCOREBOARD_EN undefined: no scoreboard state; busy_po is tied to 0 and iss_valid_pi/iss_rd_pi are ignored.

## Test plan
- Reset: hold reset 2 cycles with ALU and load inputs active. Required: we_po=0, ld_ready_po=0, busy_po=0 throughout; after release, ld_ready_po=1.
- ALU write: alu x5=0xDEADBEEF at N. Required: we_po=1, destReg_po=5, writeData_po=0xDEADBEEF at N+1. A write to x0 at N+2 gives we_po=0 at N+3.
- Collision: ALU x1=0x11 and load x2=0x22 at cycle N. Required: x1 written at N+1, x2 written at N+2, ld_ready_po stays 1.
- FIFO full:
  - With alu_valid_pi held high, push two loads. Required: ld_ready_po=0 after the second push.
  - Then drop alu_valid_pi. Required: loads drain in order and ld_ready_po returns to 1 one cycle after the first pop.
- Starvation: with a load queued and alu_valid_pi held high, alu_stall_po rises after 8 blocked cycles (STARVE_LIMIT=8). After upstream drops alu_valid_pi, the load writes and alu_stall_po falls on the edge after the pop.
- Scoreboard (WB_SCOREBOARD_EN defined):
  - Issue x7. Required: busy[7]=1 the next cycle.
  - Write x7. Required: busy[7]=0 on the edge that registers we_po=1.
  - Issue x7 and write x7 in the same cycle. Required: busy[7] stays 1.
